lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store initiator driving the word-addressed data memory (1024 x 32, comb read, write-enable).
//  Accepts one load/store request at a time from the execute stage; issues word/half/byte accesses.
//  Sub-word stores use read-modify-write. Returns a sign/zero-extended load result or a store completion.
// PARAMETERS
//  ADDR_W   10  word-address width to memory (depth = 2**ADDR_W words)
//  DATA_W   32  data width; only 32 is supported
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   unit idle, can accept
//  req_write   in   1   1 = store, 0 = load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 reserved (error)
//  req_signed  in   1   loads: 1 = sign-extend, 0 = zero-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-aligned
//  resp_valid  out  1   one-cycle completion pulse
//  resp_err    out  1   valid with resp_valid: access rejected
//  resp_rdata  out  32  load result, valid with resp_valid
//  mem_addr    out  ADDR_W  word index to memory
//  mem_wdata   out  32  write data to memory
//  mem_we      out  1   memory write enable
//  mem_rdata   in   32  combinational read data from memory
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
//  FSM IDLE -> ACCESS -> [MERGE ->] RESP -> IDLE. Accept when req_valid&req_ready (IDLE only); latch all req_*.
//  Decode at accept: err if req_size==11, or req_addr[31:ADDR_W+2]!=0, or misaligned (see CONFIGURATION).
//    err -> skip memory, go RESP directly: resp_err=1, resp_rdata=0, mem_we never asserted.
//  ACCESS: mem_addr=addr[ADDR_W+1:2]. Load: select lane (little-endian, byte lane=addr[1:0], half=addr[1]),
//    extend per size/signed, register into resp_rdata; -> RESP. Word store: mem_we=1, mem_wdata=wdata; -> RESP.
//    Sub-word store: register mem_rdata; -> MERGE.
//  MERGE: mem_we=1, mem_wdata = old word with addressed lane(s) replaced by wdata[7:0]/[15:0]; -> RESP.
//  RESP: resp_valid=1 exactly one cycle; req_ready=0; -> IDLE. resp_rdata holds until next load completes.
//  Latency (accept edge = cycle 0): load/word store resp_valid in cycle 2; sub-word store in cycle 3;
//    error in cycle 1. Back-to-back: next accept in cycle after RESP. Throughput 1 req per 3-4 cycles.
//  mem_we high only in ACCESS (word store) or MERGE; exactly one write cycle per store, none per load.
//  req_valid outside IDLE ignored; requester must hold req_* stable only until accepted.
//  Reset mid-operation: immediate return to IDLE, mem_we drops asynchronously, transaction dropped,
//    no resp_valid, no write after reset release.
//  Highest word (index 2**ADDR_W-1) legal; next byte address beyond it -> err, no wrap.
// CONFIGURATION
//  LSU_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> resp_err=1, no access.
//  Not defined: no alignment error; offending low bits treated as 0 (half uses addr[1], word uses lane 0),
//    access proceeds normally; size==11 and out-of-range still error.
// TESTING
//  Word store 0x0000_0010 <- 0xDEADBEEF, then word load -> mem_we once, mem_addr=4, rdata=0xDEADBEEF, cycle 2.
//  Byte store 0x11 to addr 0x12 over 0xDEADBEEF at word 4 -> MERGE writes 0xDE11BEEF, resp in cycle 3.
//  Byte load addr 0x13 signed from 0xDE11BEEF -> 0xFFFFFFDE; unsigned -> 0x000000DE; half addr 0x10 signed -> 0xFFFFBEEF.
//  Word load addr 0x0000_1000 (ADDR_W=10) -> resp_err=1 in cycle 1, resp_rdata=0, mem_we never high.
//  Half store addr 0x11: with LSU_ALIGN_CHECK_EN -> err, memory unchanged; without -> lanes [15:0] written.
//  Assert reset during MERGE of byte store -> mem_we low immediately, no resp_valid, memory word unchanged.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit front end for a word-addressed, combinational-read data memory.
// Optional build macro LSU_ALIGN_CHECK_EN: reject misaligned half/word accesses instead of forcing low bits to zero.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_MERGE  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte or half of the old word with the right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [15:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = old_word;
        if (size == SZ_BYTE) begin
            case (lane)
                2'd0:    r[7:0]   = wdata[7:0];
                2'd1:    r[15:8]  = wdata[7:0];
                2'd2:    r[23:16] = wdata[7:0];
                2'd3:    r[31:24] = wdata[7:0];
                default: r        = old_word;
            endcase
        end else if (lane[1]) begin
            r[31:16] = wdata;
        end else begin
            r[15:0] = wdata;
        end
        return r;
    endfunction

    logic [1:0]        state_r;
    logic              write_r;
    logic [1:0]        size_r;
    logic              signed_r;
    logic [1:0]        lane_r;
    logic [15:0]       wdata_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_we_r;

    logic              range_err_s;
    logic              align_err_s;
    logic              req_err_s;

    // Request decode at accept: reserved size, address beyond memory, optional alignment.
    always_comb begin
        range_err_s = (req_addr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
`ifdef LSU_ALIGN_CHECK_EN
        align_err_s = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
        align_err_s = 1'b0;
`endif
        if (req_size == 2'b11) begin
            req_err_s = 1'b1;
        end else begin
            req_err_s = range_err_s | align_err_s;
        end
    end

    // Transaction FSM; every output is a register so reset clears them asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            write_r      <= 1'b0;
            size_r       <= 2'b00;
            signed_r     <= 1'b0;
            lane_r       <= 2'b00;
            wdata_r      <= 16'h0000;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 32'h0000_0000;
            mem_we_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_r     <= req_write;
                        size_r      <= req_size;
                        signed_r    <= req_signed;
                        lane_r      <= req_addr[1:0];
                        wdata_r     <= req_wdata[15:0];
                        req_ready_r <= 1'b0;
                        if (req_err_s) begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r    <= ST_ACCESS;
                            mem_addr_r <= req_addr[ADDR_W+1:2];
                            if (req_write && (req_size == SZ_WORD)) begin
                                mem_we_r    <= 1'b1;
                                mem_wdata_r <= req_wdata;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!write_r) begin
                        resp_rdata_r <= load_extract(mem_rdata, size_r, lane_r, signed_r);
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                    end else if (size_r == SZ_WORD) begin
                        mem_we_r     <= 1'b0;
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                    end else begin
                        mem_wdata_r <= store_merge(mem_rdata, wdata_r, size_r, lane_r);
                        mem_we_r    <= 1'b1;
                        state_r     <= ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    mem_we_r     <= 1'b0;
                    state_r      <= ST_RESP;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                end
                ST_RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    mem_we_r     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_we     = mem_we_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 1024 x 32 combinational-read memory model.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024] = '{default: 32'h0000_0000};
    int          we_cnt = 0;
    logic [9:0]  last_we_addr = 10'd0;
    int          checks = 0;
    int          errors = 0;

    lsu_mem_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Memory write port plus write-cycle bookkeeping.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
            last_we_addr  <= mem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er);
        int  wait_c;
        logic got;
        lat = 0; rd = 32'h0; er = 1'b0; got = 1'b0; wait_c = 0;
        @(negedge clk);
        while (!req_ready && wait_c < 8) begin
            @(negedge clk);
            wait_c++;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = 32'hA5A5_A5A5;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (!got && resp_valid) begin
                got = 1'b1; lat = c; rd = resp_rdata; er = resp_err;
            end
            if (got) c = 9;
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          we0;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // word store then word load
        we0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, er);
        check("sw_lat", lat, 32'd2);
        check("sw_err", {31'd0, er}, 32'd0);
        check("sw_we_count", we_cnt - we0, 32'd1);
        check("sw_we_addr", {22'd0, last_we_addr}, 32'd4);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        @(negedge clk);
        check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
        check("ready_after_resp", {31'd0, req_ready}, 32'd1);

        we0 = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er);
        check("lw_lat", lat, 32'd2);
        check("lw_data", rd, 32'hDEAD_BEEF);
        check("lw_no_write", we_cnt - we0, 32'd0);

        // byte store via read-modify-write
        we0 = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h7777_7711, lat, rd, er);
        check("sb_lat", lat, 32'd3);
        check("sb_we_count", we_cnt - we0, 32'd1);
        check("sb_mem", mem[4], 32'hDE11_BEEF);
        check("rdata_hold_after_store", rd, 32'hDEAD_BEEF);

        // sub-word loads
        do_req(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, lat, rd, er);
        check("lb_signed", rd, 32'hFFFF_FFDE);
        check("lb_lat", lat, 32'd2);
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, lat, rd, er);
        check("lbu", rd, 32'h0000_00DE);
        do_req(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0, lat, rd, er);
        check("lb_lane1_signed", rd, 32'hFFFF_FFBE);
        do_req(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0, lat, rd, er);
        check("lh_signed", rd, 32'hFFFF_BEEF);
        do_req(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, lat, rd, er);
        check("lhu_upper", rd, 32'h0000_DE11);

        // errors: out of range and reserved size
        we0 = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, lat, rd, er);
        check("oor_err", {31'd0, er}, 32'd1);
        check("oor_lat", lat, 32'd1);
        check("oor_rdata", rd, 32'h0);
        do_req(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h1234_5678, lat, rd, er);
        check("rsv_err", {31'd0, er}, 32'd1);
        check("rsv_lat", lat, 32'd1);
        check("err_no_write", we_cnt - we0, 32'd0);
        check("rsv_mem_unchanged", mem[4], 32'hDE11_BEEF);

        // highest legal word
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'h1234_5678, lat, rd, er);
        check("top_we_addr", {22'd0, last_we_addr}, 32'd1023);
        check("top_err", {31'd0, er}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0, lat, rd, er);
        check("top_load", rd, 32'h1234_5678);

        // misaligned half store
        we0 = we_cnt;
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h1234_CAFE, lat, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
        check("sh_mis_err", {31'd0, er}, 32'd1);
        check("sh_mis_lat", lat, 32'd1);
        check("sh_mis_mem", mem[4], 32'hDE11_BEEF);
        check("sh_mis_no_write", we_cnt - we0, 32'd0);
`else
        check("sh_mis_err", {31'd0, er}, 32'd0);
        check("sh_mis_lat", lat, 32'd3);
        check("sh_mis_mem", mem[4], 32'hDE11_CAFE);
        check("sh_mis_write", we_cnt - we0, 32'd1);
`endif

        // reset during MERGE of a byte store
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h5566_7788, lat, rd, er);
        check("pre_rst_mem", mem[5], 32'h5566_7788);
        @(negedge clk);
        we0 = we_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0000_0014; req_wdata = 32'h0000_00AA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("merge_we_high", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_we_async", {31'd0, mem_we}, 32'd0);
        check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        check("post_rst_no_write", we_cnt - we0, 32'd0);
        check("post_rst_mem", mem[5], 32'h5566_7788);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0, lat, rd, er);
        check("post_rst_load", rd, 32'h5566_7788);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
